// File: rtl/axis_tp_pkg.sv
// Shared definitions for the counter test-pattern generator/checker pair:
// the pattern successor function and the checker lock states.
package axis_tp_pkg;

    localparam int TP_MAX_W = 64;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } chk_state_t;

    // Successor of d; callers zero-extend narrower values and truncate the result,
    // which keeps the arithmetic modulo 2^TDATA_WIDTH.
    function automatic logic [TP_MAX_W-1:0] tp_next(
        input logic [TP_MAX_W-1:0] d,
        input logic [TP_MAX_W-1:0] start_v,
        input logic [TP_MAX_W-1:0] end_v,
        input logic [TP_MAX_W-1:0] incr_v
    );
        logic [TP_MAX_W-1:0] r;
        if (d >= end_v) begin
            r = d - (end_v - start_v);
        end else begin
            r = d + incr_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_tp_ready_throttle.sv
// Registered tready generator: high for one cycle in every READY_PERIOD while enabled.
module axis_tp_ready_throttle #(
    parameter int READY_PERIOD = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_ready
);

    localparam int PHASE_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(READY_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);

    logic [PHASE_W-1:0] r_phase;
    logic               r_ready;

    // Phase only advances while enabled, so a pause resumes mid-period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_ready <= 1'b0;
        end else begin
            if (i_enable) begin
                r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PHASE_ONE;
            end else begin
                r_phase <= r_phase;
            end
            r_ready <= (r_phase == '0) & i_enable;
        end
    end

    assign o_ready = r_ready;

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream sink that predicts the counter test pattern beat by beat and reports
// lock, saturating beat/error counts and the last mismatched word.
module axis_testpattern_checker
    import axis_tp_pkg::*;
#(
    parameter int TDATA_WIDTH   = 32,
    parameter int COUNTER_START = 0,
    parameter int COUNTER_END   = 255,
    parameter int COUNTER_INCR  = 1,
    parameter int LOCK_COUNT    = 4,
    parameter int LOSS_COUNT    = 3,
    parameter int ERRCNT_WIDTH  = 16,
    parameter int READY_PERIOD  = 1
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_aresetn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic                    locked,
    output logic                    err_pulse,
    output logic                    err_sticky,
    output logic [ERRCNT_WIDTH-1:0] error_count,
    output logic [ERRCNT_WIDTH-1:0] beat_count,
    output logic [TDATA_WIDTH-1:0]  last_bad_data
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
    localparam logic [TDATA_WIDTH-1:0]  C_START  = TDATA_WIDTH'(COUNTER_START);
    localparam logic [TDATA_WIDTH-1:0]  C_END    = TDATA_WIDTH'(COUNTER_END);
    localparam logic [TDATA_WIDTH-1:0]  C_INCR   = TDATA_WIDTH'(COUNTER_INCR);
    localparam logic [ERRCNT_WIDTH-1:0] CNT_ONE  = ERRCNT_WIDTH'(1);
    localparam logic [GOOD_W-1:0]       GOOD_ONE = GOOD_W'(1);
    localparam logic [GOOD_W-1:0]       GOOD_MAX = GOOD_W'(LOCK_COUNT);
    localparam logic [BAD_W-1:0]        BAD_ONE  = BAD_W'(1);
    localparam logic [BAD_W-1:0]        BAD_MAX  = BAD_W'(LOSS_COUNT);

    chk_state_t              r_state, w_state_nxt;
    logic [TDATA_WIDTH-1:0]  r_expected, w_expected_nxt;
    logic [GOOD_W-1:0]       r_good, w_good_nxt;
    logic [BAD_W-1:0]        r_bad, w_bad_nxt;
    logic [ERRCNT_WIDTH-1:0] r_error_count, w_error_count_nxt;
    logic [ERRCNT_WIDTH-1:0] r_beat_count, w_beat_count_nxt;
    logic [TDATA_WIDTH-1:0]  r_last_bad, w_last_bad_nxt;
    logic                    r_err_pulse, w_err_pulse_nxt;
    logic                    r_err_sticky, w_err_sticky_nxt;
    logic                    r_locked;
    logic                    w_beat;
    logic                    w_match;
    logic [TDATA_WIDTH-1:0]  w_next;

    axis_tp_ready_throttle #(
        .READY_PERIOD (READY_PERIOD)
    ) u_throttle (
        .i_clk    (m_axis_aclk),
        .i_rst_n  (m_axis_aresetn),
        .i_enable (enable),
        .o_ready  (s_axis_tready)
    );

    // A beat is the bus handshake itself: the generator advances on it even in the
    // cycle after enable falls, so it must be consumed to stay in step.
    assign w_beat  = s_axis_tvalid & s_axis_tready;
    assign w_match = (s_axis_tdata == r_expected);
    assign w_next  = TDATA_WIDTH'(tp_next(TP_MAX_W'(s_axis_tdata), TP_MAX_W'(C_START),
                                          TP_MAX_W'(C_END), TP_MAX_W'(C_INCR)));

    // Lock FSM, prediction and counter next-state; clear takes priority over a beat.
    always_comb begin
        w_state_nxt       = r_state;
        w_expected_nxt    = r_expected;
        w_good_nxt        = r_good;
        w_bad_nxt         = r_bad;
        w_error_count_nxt = r_error_count;
        w_beat_count_nxt  = r_beat_count;
        w_last_bad_nxt    = r_last_bad;
        w_err_pulse_nxt   = 1'b0;
        w_err_sticky_nxt  = r_err_sticky;
        if (clear) begin
            w_state_nxt       = UNLOCKED;
            w_expected_nxt    = C_START;
            w_good_nxt        = '0;
            w_bad_nxt         = '0;
            w_error_count_nxt = '0;
            w_beat_count_nxt  = '0;
            w_err_sticky_nxt  = 1'b0;
        end else if (w_beat) begin
            w_expected_nxt   = w_next;
            w_beat_count_nxt = (r_beat_count == '1) ? r_beat_count : r_beat_count + CNT_ONE;
            case (r_state)
                UNLOCKED: begin
                    w_good_nxt  = GOOD_ONE;
                    w_bad_nxt   = '0;
                    w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: begin
                    w_bad_nxt = '0;
                    if (w_match) begin
                        w_good_nxt  = r_good + GOOD_ONE;
                        w_state_nxt = ((r_good + GOOD_ONE) == GOOD_MAX) ? LOCKED : ACQUIRE;
                    end else begin
                        w_good_nxt = GOOD_ONE;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_pulse_nxt   = 1'b1;
                        w_err_sticky_nxt  = 1'b1;
                        w_last_bad_nxt    = s_axis_tdata;
                        w_error_count_nxt = (r_error_count == '1) ? r_error_count
                                                                  : r_error_count + CNT_ONE;
                        if ((r_bad + BAD_ONE) == BAD_MAX) begin
                            w_bad_nxt   = '0;
                            w_state_nxt = UNLOCKED;
                        end else begin
                            w_bad_nxt = r_bad + BAD_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = UNLOCKED;
                end
            endcase
        end else begin
            w_err_pulse_nxt = 1'b0;
        end
    end

    // State and output registers; locked tracks the state it enters on the same edge.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_state       <= UNLOCKED;
            r_expected    <= C_START;
            r_good        <= '0;
            r_bad         <= '0;
            r_error_count <= '0;
            r_beat_count  <= '0;
            r_last_bad    <= '0;
            r_err_pulse   <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_expected    <= w_expected_nxt;
            r_good        <= w_good_nxt;
            r_bad         <= w_bad_nxt;
            r_error_count <= w_error_count_nxt;
            r_beat_count  <= w_beat_count_nxt;
            r_last_bad    <= w_last_bad_nxt;
            r_err_pulse   <= w_err_pulse_nxt;
            r_err_sticky  <= w_err_sticky_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
        end
    end

    assign locked        = r_locked;
    assign err_pulse     = r_err_pulse;
    assign err_sticky    = r_err_sticky;
    assign error_count   = r_error_count;
    assign beat_count    = r_beat_count;
    assign last_bad_data = r_last_bad;

endmodule
